ex_cond_stage: RTL and testbench
================================

Name: ex_cond_stage

Overview:
- Execute-stage control block of the pipelined CPU; sits directly downstream of the instruction decoder (decoder_v).
- Registers the decoder's control word into the ID/EX pipeline register and holds the architectural NZCV flags register.
- Evaluates the 4-bit condition field against the current flags.
- Gates the side-effecting controls (register write, memory write, PC write, branch) so a failed condition becomes a no-op.

Parameters:
- ALU_CTRL_W, 2, width of ALU control field
- COND_W, 4, width of condition field (fixed 4; parameter for documentation only)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- stall_e  in  1  hold ID/EX register contents this cycle
- flush_e  in  1  load a bubble into ID/EX at next edge
- pcs_d  in  1  decoder: instruction writes PC
- reg_w_d  in  1  decoder: register write
- mem_w_d  in  1  decoder: memory write (decoder MemW)
- mem_to_reg_d  in  1  decoder: writeback select
- alu_src_d  in  1  decoder: ALU B-operand select
- alu_ctrl_d  in  ALU_CTRL_W  decoder: ALU operation
- flag_w_d  in  2  decoder: [1]=write N,Z; [0]=write C,V
- branch_d  in  1  decoder: B instruction
- cond_d  in  4  instruction bits [31:28]
- alu_flags_e  in  4  ALU result flags {N,Z,C,V}, same cycle
- pc_src_e  out  1  gated PC write
- reg_write_e  out  1  gated register write
- mem_write_e  out  1  gated memory write
- branch_taken_e  out  1  gated branch
- mem_to_reg_e  out  1  registered, ungated
- alu_src_e  out  1  registered, ungated
- alu_ctrl_e  out  ALU_CTRL_W  registered, ungated
- cond_ex_e  out  1  condition passed
- flags_q  out  4  current architectural {N,Z,C,V}

Behaviour:
- ID/EX register: rst_n=0 at an edge sets all control fields to 0 and cond to 4'b1110 (AL); flags_q <= 4'b0000.
- Priority at each edge: reset > flush_e > stall_e > normal load.
  - flush_e loads the bubble value (same as reset, flags untouched).
  - stall_e holds.
  - Otherwise the register captures the *_d inputs.
- Latency: a decoder output presented in cycle t appears on the *_e outputs in cycle t+1.
- Condition check (combinational on registered cond and flags_q):
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C&!Z
  - LS 1001: !C|Z
  - GE 1010: N==V
  - LT 1011: N!=V
  - GT 1100: !Z&(N==V)
  - LE 1101: Z|(N!=V)
  - AL 1110: 1
  - 1111: 1 (treated as unconditional)
- Gating:
  - reg_write_e, mem_write_e, pc_src_e and branch_taken_e each equal their registered value AND cond_ex_e AND !stall_e.
  - While stall_e=1 all four are 0.
- Flag write, at the edge ending cycle t, only if cond_ex_e=1 and stall_e=0:
  - flag_w[1] updates N,Z from alu_flags_e[3:2].
  - flag_w[0] updates C,V from alu_flags_e[1:0].
  - flush_e in the same cycle does not block this write, because the instruction leaving E is still valid.
- Back-to-back: flags written by the instruction in E at cycle t are seen by the condition check of the instruction in E at cycle t+1. No bubble is required.
- Reset mid-operation: the in-flight instruction is discarded, no flag write occurs, and all gated outputs are 0 in the cycle after reset.
- A bubble (all-zero control, AL) produces no side effects and does not change flags.

Decomposition:
- Shared package cpu_pkg:
  - COND_* localparams (EQ..AL)
  - flag bit indices N=3, Z=2, C=1, V=0
  - bubble control constant
- One sub-module: cond_check (pure combinational; cond[3:0], flags[3:0] -> cond_ex).
- The register, flag storage and gating stay in ex_cond_stage.

Test Plan:
- Reset: rst_n=0 for 2 cycles with nonzero inputs -> all outputs 0, flags_q=0000, cond_ex_e=1 (AL bubble).
- STR passes: mem_w_d=1, cond_d=1110 -> next cycle mem_write_e=1, reg_write_e=0.
- CMP then BEQ:
  - CMP: flag_w_d=11, alu_flags_e=0100 in E.
  - Next instruction branch_d=1, pcs_d=1, cond_d=0000 -> flags_q=0100, branch_taken_e=1, pc_src_e=1 with no bubble.
- Failed condition: flags_q=0000, ADDEQ with reg_w_d=1, flag_w_d=11, alu_flags_e=1000 -> reg_write_e=0, flags_q stays 0000.
- Stall: stall_e=1 for 2 cycles with STR in E -> mem_write_e=0 both cycles and contents held; stall_e=0 -> mem_write_e=1 for exactly one cycle.
- Flush with stall: flush_e=1 and stall_e=1 on the same edge -> bubble loaded, all gated outputs 0; exhaustive sweep of cond_check over 16 conds × 16 flag values against the table above.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, NZCV bit positions and the
// execute-stage control word with its bubble value.
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ALU control lives outside the struct so its width can stay a module parameter.
  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] flag_w;
    logic       branch;
    logic [3:0] cond;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    pcs: 1'b0, reg_w: 1'b0, mem_w: 1'b0, mem_to_reg: 1'b0,
    alu_src: 1'b0, flag_w: 2'b00, branch: 1'b0, cond: COND_AL
  };

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against NZCV flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b1; // 1111 behaves as always
    endcase
  end

endmodule

// File: rtl/ex_cond_stage.sv
// ID/EX control register, NZCV flags register and condition-based gating
// of side-effecting controls in the execute stage.
module ex_cond_stage
  import cpu_pkg::*;
#(
  parameter int ALU_CTRL_W = 2,
  parameter int COND_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  pcs_d,
  input  logic                  reg_w_d,
  input  logic                  mem_w_d,
  input  logic                  mem_to_reg_d,
  input  logic                  alu_src_d,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl_d,
  input  logic [1:0]            flag_w_d,
  input  logic                  branch_d,
  input  logic [COND_W-1:0]     cond_d,
  input  logic [3:0]            alu_flags_e,
  output logic                  pc_src_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  branch_taken_e,
  output logic                  mem_to_reg_e,
  output logic                  alu_src_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic                  cond_ex_e,
  output logic [3:0]            flags_q
);

  ctrl_t                 ctrl_reg;
  ctrl_t                 ctrl_next;
  logic [ALU_CTRL_W-1:0] alu_ctrl_reg;
  logic [3:0]            flags_reg;
  logic                  commit;

  assign ctrl_next = '{
    pcs: pcs_d, reg_w: reg_w_d, mem_w: mem_w_d, mem_to_reg: mem_to_reg_d,
    alu_src: alu_src_d, flag_w: flag_w_d, branch: branch_d, cond: cond_d
  };

  // The instruction in E takes effect only if its condition passes and it is not stalled.
  assign commit = cond_ex_e & ~stall_e;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_reg     <= CTRL_BUBBLE;
      alu_ctrl_reg <= '0;
      flags_reg    <= 4'b0000;
    end else begin
      if (flush_e) begin
        ctrl_reg     <= CTRL_BUBBLE;
        alu_ctrl_reg <= '0;
      end else if (!stall_e) begin
        ctrl_reg     <= ctrl_next;
        alu_ctrl_reg <= alu_ctrl_d;
      end
      // A flush only discards the incoming instruction; the one leaving E still commits.
      if (commit) begin
        if (ctrl_reg.flag_w[1]) flags_reg[FLAG_N:FLAG_Z] <= alu_flags_e[FLAG_N:FLAG_Z];
        if (ctrl_reg.flag_w[0]) flags_reg[FLAG_C:FLAG_V] <= alu_flags_e[FLAG_C:FLAG_V];
      end
    end
  end

  cond_check u_cond_check (
    .cond    (ctrl_reg.cond),
    .flags   (flags_reg),
    .cond_ex (cond_ex_e)
  );

  assign pc_src_e       = ctrl_reg.pcs    & commit;
  assign reg_write_e    = ctrl_reg.reg_w  & commit;
  assign mem_write_e    = ctrl_reg.mem_w  & commit;
  assign branch_taken_e = ctrl_reg.branch & commit;
  assign mem_to_reg_e   = ctrl_reg.mem_to_reg;
  assign alu_src_e      = ctrl_reg.alu_src;
  assign alu_ctrl_e     = alu_ctrl_reg;
  assign flags_q        = flags_reg;

endmodule

// File: tb/tb_ex_cond_stage.sv
// Self-checking bench for ex_cond_stage: directed scenarios, a full condition
// sweep and a randomized run against a cycle-level behavioural model.
module tb_ex_cond_stage;

  logic       clk = 1'b0;
  logic       rst_n, stall_e, flush_e;
  logic       pcs_d, reg_w_d, mem_w_d, mem_to_reg_d, alu_src_d, branch_d;
  logic [1:0] alu_ctrl_d, flag_w_d;
  logic [3:0] cond_d, alu_flags_e;
  logic       pc_src_e, reg_write_e, mem_write_e, branch_taken_e;
  logic       mem_to_reg_e, alu_src_e, cond_ex_e;
  logic [1:0] alu_ctrl_e;
  logic [3:0] flags_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_cond_stage #(.ALU_CTRL_W(2), .COND_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .pcs_d(pcs_d), .reg_w_d(reg_w_d), .mem_w_d(mem_w_d),
    .mem_to_reg_d(mem_to_reg_d), .alu_src_d(alu_src_d), .alu_ctrl_d(alu_ctrl_d),
    .flag_w_d(flag_w_d), .branch_d(branch_d), .cond_d(cond_d),
    .alu_flags_e(alu_flags_e), .pc_src_e(pc_src_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .branch_taken_e(branch_taken_e),
    .mem_to_reg_e(mem_to_reg_e), .alu_src_e(alu_src_e), .alu_ctrl_e(alu_ctrl_e),
    .cond_ex_e(cond_ex_e), .flags_q(flags_q)
  );

  // Paired-condition formulation: odd codes are the negation of the even code below them.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [12:0] out_vec();
    return {pc_src_e, reg_write_e, mem_write_e, branch_taken_e, mem_to_reg_e,
            alu_src_e, alu_ctrl_e, cond_ex_e, flags_q};
  endfunction

  task automatic drive_idle();
    rst_n = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    pcs_d = 1'b0; reg_w_d = 1'b0; mem_w_d = 1'b0; mem_to_reg_d = 1'b0;
    alu_src_d = 1'b0; alu_ctrl_d = 2'b00; flag_w_d = 2'b00; branch_d = 1'b0;
    cond_d = 4'b1110; alu_flags_e = 4'b0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0; pcs_d = 1'b1; reg_w_d = 1'b1; mem_w_d = 1'b1; mem_to_reg_d = 1'b1;
    alu_src_d = 1'b1; alu_ctrl_d = 2'b11; flag_w_d = 2'b11; branch_d = 1'b1;
    cond_d = 4'b0000; alu_flags_e = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (out_vec() !== 13'b0000_00_00_1_0000) begin
        n_fail++;
        $display("FAIL reset cycle %0d: outputs=%b expected=%b", i, out_vec(), 13'b0000_00_00_1_0000);
      end
    end
    drive_idle();
    tick();
    $display("test_reset done");
  endtask

  task automatic test_str();
    drive_idle();
    mem_w_d = 1'b1;
    tick();
    drive_idle();
    n_checks++;
    if ({mem_write_e, reg_write_e} !== 2'b10) begin
      n_fail++;
      $display("FAIL str: mem_write,reg_write=%b expected=10", {mem_write_e, reg_write_e});
    end
    tick();
    $display("test_str done");
  endtask

  task automatic test_cmp_beq();
    drive_idle();
    flag_w_d = 2'b11; alu_ctrl_d = 2'b01;
    tick();
    drive_idle();
    alu_flags_e = 4'b0100;
    branch_d = 1'b1; pcs_d = 1'b1; cond_d = 4'b0000;
    tick();
    drive_idle();
    n_checks++;
    if ({flags_q, branch_taken_e, pc_src_e, cond_ex_e} !== 7'b0100_111) begin
      n_fail++;
      $display("FAIL cmp_beq: flags,br,pc,cond_ex=%b expected=0100111",
               {flags_q, branch_taken_e, pc_src_e, cond_ex_e});
    end
    tick();
    $display("test_cmp_beq done");
  endtask

  task automatic test_failed_cond();
    drive_idle();
    flag_w_d = 2'b11;
    tick();
    drive_idle();
    alu_flags_e = 4'b0000;
    reg_w_d = 1'b1; flag_w_d = 2'b11; cond_d = 4'b0000;
    tick();
    drive_idle();
    alu_flags_e = 4'b1000;
    n_checks++;
    if ({flags_q, reg_write_e, cond_ex_e} !== 6'b0000_00) begin
      n_fail++;
      $display("FAIL failed_cond gate: flags,reg_write,cond_ex=%b expected=000000",
               {flags_q, reg_write_e, cond_ex_e});
    end
    tick();
    n_checks++;
    if (flags_q !== 4'b0000) begin
      n_fail++;
      $display("FAIL failed_cond flags: flags_q=%b expected=0000", flags_q);
    end
    $display("test_failed_cond done");
  endtask

  task automatic test_stall();
    drive_idle();
    mem_w_d = 1'b1; alu_src_d = 1'b1; alu_ctrl_d = 2'b10;
    tick();
    drive_idle();
    stall_e = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({mem_write_e, alu_src_e, alu_ctrl_e} !== 4'b0110) begin
        n_fail++;
        $display("FAIL stall cycle %0d: mem_write,alu_src,alu_ctrl=%b expected=0110",
                 i, {mem_write_e, alu_src_e, alu_ctrl_e});
      end
      tick();
    end
    stall_e = 1'b0;
    #1;
    n_checks++;
    if (mem_write_e !== 1'b1) begin
      n_fail++;
      $display("FAIL stall release: mem_write_e=%b expected=1", mem_write_e);
    end
    tick();
    n_checks++;
    if (mem_write_e !== 1'b0) begin
      n_fail++;
      $display("FAIL stall one-shot: mem_write_e=%b expected=0", mem_write_e);
    end
    $display("test_stall done");
  endtask

  task automatic test_flush_stall();
    drive_idle();
    pcs_d = 1'b1; reg_w_d = 1'b1; mem_w_d = 1'b1; branch_d = 1'b1;
    alu_src_d = 1'b1; mem_to_reg_d = 1'b1; alu_ctrl_d = 2'b11;
    tick();
    flush_e = 1'b1; stall_e = 1'b1;
    tick();
    drive_idle();
    n_checks++;
    if (out_vec() !== {9'b0000_00_00_1, flags_q}) begin
      n_fail++;
      $display("FAIL flush_stall: outputs=%b expected=%b", out_vec(), {9'b0000_00_00_1, flags_q});
    end
    // Flush must not block the flag write of the instruction leaving E.
    flag_w_d = 2'b11;
    tick();
    drive_idle();
    flush_e = 1'b1; alu_flags_e = 4'b1111;
    tick();
    drive_idle();
    n_checks++;
    if ({flags_q, reg_write_e} !== 5'b1111_0) begin
      n_fail++;
      $display("FAIL flush_flag_write: flags,reg_write=%b expected=11110", {flags_q, reg_write_e});
    end
    $display("test_flush_stall done");
  endtask

  task automatic test_cond_sweep();
    int errs;
    errs = 0;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive_idle();
        flag_w_d = 2'b11;
        tick();
        drive_idle();
        alu_flags_e = 4'(f);
        reg_w_d = 1'b1; cond_d = 4'(c);
        tick();
        drive_idle();
        n_checks++;
        if ({flags_q, cond_ex_e, reg_write_e} !==
            {4'(f), cond_model(4'(c), 4'(f)), cond_model(4'(c), 4'(f))}) begin
          n_fail++; errs++;
          $display("FAIL cond_sweep cond=%b flags=%b: got flags,cond_ex,reg_write=%b expected=%b%b%b",
                   4'(c), 4'(f), {flags_q, cond_ex_e, reg_write_e}, 4'(f),
                   cond_model(4'(c), 4'(f)), cond_model(4'(c), 4'(f)));
        end
      end
    end
    $display("test_cond_sweep done: 256 combinations, %0d errors", errs);
  endtask

  task automatic test_random();
    logic       m_pcs, m_regw, m_memw, m_m2r, m_asrc, m_br, m_ok;
    logic [1:0] m_alu, m_fw;
    logic [3:0] m_cond, m_flags;
    logic [12:0] exp_v;
    int errs;
    errs = 0;
    drive_idle();
    rst_n = 1'b0;
    tick();
    {m_pcs, m_regw, m_memw, m_m2r, m_asrc, m_br} = '0;
    m_alu = 2'b00; m_fw = 2'b00; m_cond = 4'b1110; m_flags = 4'b0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n        = ($urandom_range(0, 31) != 0);
      stall_e      = ($urandom_range(0, 4) == 0);
      flush_e      = ($urandom_range(0, 7) == 0);
      pcs_d        = 1'($urandom); reg_w_d   = 1'($urandom);
      mem_w_d      = 1'($urandom); branch_d  = 1'($urandom);
      mem_to_reg_d = 1'($urandom); alu_src_d = 1'($urandom);
      alu_ctrl_d   = 2'($urandom); flag_w_d  = 2'($urandom);
      cond_d       = 4'($urandom); alu_flags_e = 4'($urandom);
      #1;
      m_ok = cond_model(m_cond, m_flags) && !stall_e;
      exp_v = {m_pcs && m_ok, m_regw && m_ok, m_memw && m_ok, m_br && m_ok,
               m_m2r, m_asrc, m_alu, cond_model(m_cond, m_flags), m_flags};
      n_checks++;
      if (out_vec() !== exp_v) begin
        n_fail++; errs++;
        $display("FAIL random cycle %0d: outputs=%b expected=%b", cyc, out_vec(), exp_v);
      end
      if (!rst_n) begin
        {m_pcs, m_regw, m_memw, m_m2r, m_asrc, m_br} = '0;
        m_alu = 2'b00; m_fw = 2'b00; m_cond = 4'b1110; m_flags = 4'b0000;
      end else begin
        if (m_ok && m_fw[1]) m_flags[3:2] = alu_flags_e[3:2];
        if (m_ok && m_fw[0]) m_flags[1:0] = alu_flags_e[1:0];
        if (flush_e) begin
          {m_pcs, m_regw, m_memw, m_m2r, m_asrc, m_br} = '0;
          m_alu = 2'b00; m_fw = 2'b00; m_cond = 4'b1110;
        end else if (!stall_e) begin
          {m_pcs, m_regw, m_memw, m_m2r, m_asrc, m_br} =
            {pcs_d, reg_w_d, mem_w_d, mem_to_reg_d, alu_src_d, branch_d};
          m_alu = alu_ctrl_d; m_fw = flag_w_d; m_cond = cond_d;
        end
      end
      tick();
    end
    drive_idle();
    $display("test_random done: 400 cycles, %0d errors", errs);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_str();
    test_cmp_beq();
    test_failed_cond();
    test_stall();
    test_flush_stall();
    test_cond_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
